// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the femtoRV32 fetch stage: widths, reset PC, bubble encoding
// and the fetch state encoding.
package fetch_stage_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. flush beats hold beats load; a flush inserts a bubble and
// leaves pc/pc_plus4 untouched so downstream debug still sees the last real PC.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic            hold,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [XLEN-1:0] fetch_pc_plus4,
  input  logic [XLEN-1:0] fetch_instr,
  input  logic            fetch_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] instr,
  output logic            valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= '0;
      pc_plus4 <= 32'd4;
      instr    <= NOP;
      valid    <= 1'b0;
    end else if (flush) begin
      instr <= NOP;
      valid <= 1'b0;
    end else if (hold) begin
      pc       <= pc;
      pc_plus4 <= pc_plus4;
      instr    <= instr;
      valid    <= valid;
    end else if (load) begin
      pc       <= fetch_pc;
      pc_plus4 <= fetch_pc_plus4;
      instr    <= fetch_instr;
      valid    <= fetch_valid;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// femtoRV32 instruction-fetch stage: PC register, fetch FSM and IF/ID register.
// Optional stall/bubble counters are built when FETCH_STATS_EN is defined.
//
// state  | meaning
// BOOT   | single idle cycle after reset release, no fetch request
// RUN    | fetching; redirect > halt > stall > wait-for-ready > advance
// HALTED | fetch stopped, PC frozen, IF/ID bubbled each cycle; only reset exits
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  input  logic                  halt_req,
  output logic                  imem_req,
  output logic [XLEN-1:0]       imem_addr,
  input  logic [XLEN-1:0]       imem_rdata,
  input  logic                  imem_ready,
  output logic [XLEN-1:0]       if_id_pc,
  output logic [XLEN-1:0]       if_id_pc_plus4,
  output logic [XLEN-1:0]       if_id_instr,
  output logic                  if_id_valid,
  output logic [REG_ADDR_W-1:0] if_id_rs1,
  output logic [REG_ADDR_W-1:0] if_id_rs2
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           bubble_cycles
`endif
);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] pc_plus4;
  logic            ifid_load, ifid_flush, ifid_hold;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    imem_req   = 1'b0;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_hold  = 1'b0;
    unique case (state)
      ST_BOOT: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          // Redirect comes from an older instruction, so it wins over stall/halt.
          pc_next    = {redirect_pc[XLEN-1:2], 2'b00};
          ifid_flush = 1'b1;
        end else if (halt_req) begin
          state_next = ST_HALTED;
          ifid_flush = 1'b1;
        end else if (stall) begin
          ifid_hold = 1'b1;
        end else if (!imem_ready) begin
          ifid_flush = 1'b1;
        end else begin
          ifid_load = 1'b1;
          pc_next   = pc_plus4;
        end
      end
      ST_HALTED: begin
        ifid_flush = 1'b1;
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  if_id_reg #(.NOP(NOP_INSTR)) u_if_id_reg (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (ifid_load),
    .flush          (ifid_flush),
    .hold           (ifid_hold),
    .fetch_pc       (pc),
    .fetch_pc_plus4 (pc_plus4),
    .fetch_instr    (imem_rdata),
    .fetch_valid    (1'b1),
    .pc             (if_id_pc),
    .pc_plus4       (if_id_pc_plus4),
    .instr          (if_id_instr),
    .valid          (if_id_valid)
  );

  assign if_id_rs1 = if_id_instr[19:15];
  assign if_id_rs2 = if_id_instr[24:20];

`ifdef FETCH_STATS_EN
  logic stall_evt, bubble_evt;

  assign stall_evt  = (state == ST_RUN) && !redirect_valid && !halt_req && stall;
  assign bubble_evt = (state == ST_RUN) &&
                      (redirect_valid || halt_req || (!stall && !imem_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else begin
      if (stall_evt && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (bubble_evt && (bubble_cycles != 32'hFFFF_FFFF))
        bubble_cycles <= bubble_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect_valid, halt_req, imem_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr;
  logic        if_id_valid;
  logic [4:0]  if_id_rs1, if_id_rs2;
`ifdef FETCH_STATS_EN
  logic [31:0] stall_cycles, bubble_cycles;
`endif

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid),
    .if_id_rs1      (if_id_rs1),
    .if_id_rs2      (if_id_rs2)
`ifdef FETCH_STATS_EN
    ,
    .stall_cycles   (stall_cycles),
    .bubble_cycles  (bubble_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model
  int          m_mode;
  int          m_halt_age;
  logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr;
  logic        m_valid;
  longint      m_stalls, m_bubbles;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_BOOT; m_halt_age = 0;
    m_pc = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h4; m_instr = NOP; m_valid = 1'b0;
    m_stalls = 0; m_bubbles = 0;
  endtask

  task automatic check_ifid();
    chk("if_id_pc",       if_id_pc,       m_ifpc);
    chk("if_id_pc_plus4", if_id_pc_plus4, m_ifpc4);
    chk("if_id_instr",    if_id_instr,    m_instr);
    chk("if_id_valid",    32'(if_id_valid), 32'(m_valid));
    chk("if_id_rs1",      32'(if_id_rs1), 32'(m_instr[19:15]));
    chk("if_id_rs2",      32'(if_id_rs2), 32'(m_instr[24:20]));
`ifdef FETCH_STATS_EN
    chk("stall_cycles",  stall_cycles,  (m_stalls  > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_stalls));
    chk("bubble_cycles", bubble_cycles, (m_bubbles > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_bubbles));
`endif
  endtask

  // Entered and left at a falling edge: drive, check fetch request, clock, check IF/ID.
  task automatic step(input logic s, input logic r, input logic [31:0] rp,
                      input logic h, input logic rdy, input logic [31:0] rd);
    stall = s; redirect_valid = r; redirect_pc = rp; halt_req = h;
    imem_ready = rdy; imem_rdata = rd;
    #1;
    chk("imem_req",  32'(imem_req), (m_mode == M_RUN) ? 32'd1 : 32'd0);
    chk("imem_addr", imem_addr, m_pc);
    @(posedge clk);
    case (m_mode)
      M_BOOT: m_mode = M_RUN;
      M_HALT: begin m_instr = NOP; m_valid = 1'b0; m_halt_age++; end
      default: begin
        if (r) begin
          m_pc = rp & 32'hFFFF_FFFC; m_instr = NOP; m_valid = 1'b0; m_bubbles++;
        end else if (h) begin
          m_mode = M_HALT; m_halt_age = 0; m_instr = NOP; m_valid = 1'b0; m_bubbles++;
        end else if (s) begin
          m_stalls++;
        end else if (!rdy) begin
          m_instr = NOP; m_valid = 1'b0; m_bubbles++;
        end else begin
          m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4; m_instr = rd; m_valid = 1'b1;
          m_pc = m_pc + 32'd4;
        end
      end
    endcase
    #1;
    check_ifid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    check_ifid();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input logic rdy, input logic [31:0] rd);
    step(1'b0, 1'b0, 32'h0, 1'b0, rdy, rd);
  endtask

  task automatic go_to(input logic [31:0] target);
    step(1'b0, 1'b1, target, 1'b0, 1'b1, 32'hDEAD_BEEF);
  endtask

  initial begin
    stall = 0; redirect_valid = 0; redirect_pc = 0; halt_req = 0;
    imem_ready = 0; imem_rdata = 0; rst_n = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // boot: one idle cycle, then first fetch at address 0
    idle(1'b1, 32'h00A0_0093);
    idle(1'b1, 32'h00A0_0093);
    chk("boot_instr", if_id_instr, 32'h00A0_0093);
    chk("boot_pc_next", imem_addr, 32'h4);

    // load-use stall with a lw in IF/ID at PC 0x10
    go_to(32'h0000_000C);
    idle(1'b1, 32'h0002_A103);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_1111);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h2222_2222);
    chk("stall_resume_addr", imem_addr, 32'h10);
    idle(1'b1, 32'h0041_8233);

    // redirect wins over stall, low bits cleared
    step(1'b1, 1'b1, 32'h0000_0203, 1'b0, 1'b1, 32'h3333_3333);
    chk("redir_pc", imem_addr, 32'h200);

    // slow memory at 0x40
    go_to(32'h0000_0040);
    repeat (3) idle(1'b0, 32'h4444_4444);
    idle(1'b1, 32'h0050_0513);
    chk("slow_if_pc", if_id_pc, 32'h40);

    // PC wrap
    go_to(32'hFFFF_FFFC);
    idle(1'b1, 32'h0060_0593);
    chk("wrap_pc", imem_addr, 32'h0);

    // halt at 0x80, redirects ignored, reset recovers
    go_to(32'h0000_0080);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0073);
    for (int i = 0; i < 12; i++)
      step(1'($urandom_range(0, 1)), 1'(i == 5), 32'h0000_0400, 1'b0, 1'b1, $urandom);
    chk("halt_pc_frozen", imem_addr, 32'h80);
    do_reset();
    chk("post_halt_reset_pc", imem_addr, 32'h0);

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0 || (m_mode == M_HALT && m_halt_age > 4))
        do_reset();
      else
        step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0), $urandom,
             1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the femtoRV32 5-stage pipeline: owns the PC register and the IF/ID pipeline register.
- Consumes the load-use `stall` produced by the hazard detector.
- Consumes the branch/jump redirect from EX/MEM and a halt request from decode.
- Feeds IF/ID rs1/rs2 back to the hazard detector.
- Handles an instruction-memory ready handshake; the memory may take multiple cycles.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID on flush.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  load-use stall from hazard detector; hold PC and IF/ID.
- redirect_valid  input  1  taken branch/jump resolved in EX/MEM.
- redirect_pc  input  32  target PC for the redirect.
- halt_req  input  1  ECALL/EBREAK/FENCE decoded; stop fetching.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address; equals the current PC.
- imem_rdata  input  32  instruction word.
- imem_ready  input  1  imem_rdata valid for imem_addr this cycle.
- if_id_pc  output  32  PC of the instruction in IF/ID.
- if_id_pc_plus4  output  32  if_id_pc + 4.
- if_id_instr  output  32  instruction in IF/ID.
- if_id_valid  output  1  IF/ID holds a real instruction.
- if_id_rs1  output  5  if_id_instr[19:15], to the hazard detector.
- if_id_rs2  output  5  if_id_instr[24:20], to the hazard detector.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=BOOT, PC=RESET_PC.
  - if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc=0, if_id_pc_plus4=4.
  - imem_req=0.
- State machine:
  - BOOT: lasts exactly one cycle after rst_n deasserts, with imem_req=0. Then goes to RUN.
  - RUN: imem_req=1.
  - HALTED: imem_req=0. PC is frozen. IF/ID gets a bubble every cycle. Only reset exits HALTED.
- Per-cycle update in RUN, first matching rule wins:
  1. redirect_valid:
     - PC <= {redirect_pc[31:2],2'b00}; the low bits are forced to 0.
     - IF/ID <= bubble (NOP_INSTR, valid=0).
     - Overrides stall and halt_req; the branch is older.
     - Any pending fetch is discarded.
  2. halt_req:
     - Enter HALTED; PC is held.
     - IF/ID <= bubble.
  3. stall:
     - PC and all IF/ID fields hold their value.
     - imem_ready is ignored; the same address is refetched later.
  4. !imem_ready:
     - PC holds.
     - IF/ID <= bubble; downstream sees valid=0.
  5. Otherwise:
     - IF/ID <= {pc, pc+4, imem_rdata, valid=1}.
     - PC <= PC+4.
- Bubble contents: if_id_instr=NOP_INSTR, if_id_valid=0. if_id_pc and if_id_pc_plus4 hold their previous values.
- PC arithmetic is 32-bit modulo: PC=32'hFFFF_FFFC advances to 0 with no flag.
- imem_addr is combinational from the PC register. Fetch latency is 0 cycles when imem_ready is already high.
- if_id_rs1/if_id_rs2 are pure slices of if_id_instr. They are valid even when if_id_valid=0; NOP yields rs1=0, and the hazard detector ignores x0.
- Reset asserted mid-fetch or mid-stall aborts immediately. There is no residual state.
- redirect_valid in BOOT is ignored. redirect_valid in HALTED is ignored.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - Add outputs stall_cycles[31:0] and bubble_cycles[31:0], both reset to 0.
  - stall_cycles increments on each RUN cycle where rule 3 applies.
  - bubble_cycles increments on each RUN cycle where rule 1, 2 or 4 applies.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - NOP_INSTR.
  - RESET_PC default.
  - fetch state encoding (BOOT=2'd0, RUN=2'd1, HALTED=2'd2).
  - IF/ID field widths (XLEN=32, REG_ADDR_W=5).
- One sub-module, if_id_reg: the IF/ID pipeline register.
  - Inputs: load, flush, hold.
  - Carries pc, pc_plus4, instr and valid.
  - Also reusable by the branch-flush logic.
- PC and state machine stay in fetch_stage.

Test Plan:
- Reset release with imem_ready=1 and the memory returning 0x00A00093 at address 0:
  - Cycle 1: imem_req=0.
  - Cycle 2: imem_addr=0.
  - Cycle 3: if_id_instr=0x00A00093, if_id_valid=1, if_id_pc=0, PC=4.
- stall=1 for 2 cycles with PC=0x10 and IF/ID holding a lw:
  - PC stays 0x10 and IF/ID is unchanged for both cycles.
  - Fetch resumes at 0x10 the cycle after.
- redirect_valid=1 with redirect_pc=0x203 together with stall=1:
  - Next cycle: PC=0x200, if_id_valid=0, if_id_instr=0x00000013.
- imem_ready low for 3 cycles at PC=0x40:
  - 3 bubbles, PC holds 0x40.
  - On the 4th cycle the word is latched with if_id_pc=0x40.
- halt_req=1 at PC=0x80:
  - State goes to HALTED, imem_req=0, PC stays 0x80 for 10+ cycles.
  - A later redirect_valid is ignored.
  - rst_n=0 returns PC to RESET_PC.
- PC=0xFFFFFFFC, ready, no stall:
  - if_id_pc=0xFFFFFFFC, if_id_pc_plus4=0, PC wraps to 0.
  - With FETCH_STATS_EN: stall_cycles and bubble_cycles counts match the scenarios above.
